debounce_sync_fsm: RTL and testbench
====================================

Name: debounce_sync_fsm

Overview:
- Conditions one raw, asynchronous mechanical input (push-button or slide switch) into a clean, clock-synchronous, debounced level.
- Sits directly upstream of the one-shot pulse generator: output y drives the one-shot's level input x.
- Also provides registered single-cycle rise/fall strobes for consumers that need edge events without a separate one-shot.
- One instance per board input.

Parameters:
- PARM_DEBOUNCE_CYCLES, default 500000, number of consecutive synchronized samples of equal value required to accept a level change. Legal range >= 2; the bench uses 4.
- PARM_RESET_LEVEL, default 1'b0, debounced level and FSM stable state loaded at reset.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  synchronous reset, active-low; sampled on posedge clk.
- x  input  1  raw asynchronous input; may bounce or glitch.
- y  output  1  debounced, registered level.
- y_rise  output  1  registered strobe, high for exactly one cycle when y goes 0->1.
- y_fall  output  1  registered strobe, high for exactly one cycle when y goes 1->0.

Behaviour:
- Reset (rstn==0 at posedge):
  - sync FFs s_meta and s_sync <= PARM_RESET_LEVEL.
  - FSM <= ST_LOW if PARM_RESET_LEVEL==0, else ST_HIGH.
  - counter <= 0.
  - y <= PARM_RESET_LEVEL; y_rise <= 0; y_fall <= 0.
  - Reset has priority over all other events, including mid-pending state; any pending count is discarded.
- Synchronizer: two-FF chain, s_meta <= x, s_sync <= s_meta. The FSM sees s_sync only.
- Counter: width $clog2(PARM_DEBOUNCE_CYCLES); never wraps. Counts 0..N-1 (N = PARM_DEBOUNCE_CYCLES).
- FSM states and transitions (evaluated each posedge, rstn==1):
  - ST_LOW: s_sync==1 -> ST_RISE_PEND, counter<=0; else stay.
  - ST_RISE_PEND: s_sync==0 -> ST_LOW, counter<=0. Else if counter==N-1 -> ST_HIGH. Else counter++.
  - ST_HIGH: s_sync==0 -> ST_FALL_PEND, counter<=0; else stay.
  - ST_FALL_PEND: s_sync==1 -> ST_HIGH, counter<=0. Else if counter==N-1 -> ST_LOW. Else counter++.
  - Illegal/default encoding -> ST_LOW.
- Output decode:
  - Combinational level = 1 in ST_HIGH and ST_FALL_PEND, 0 in ST_LOW and ST_RISE_PEND.
  - Registered: y <= level.
  - y_rise <= level & ~y; y_fall <= ~level & y. Both strobes are registered in the same edge as y's change, so each strobe coincides with the first cycle of the new y value.
- Latency: x first sampled high at edge k and held -> ST_RISE_PEND at k+2 -> ST_HIGH at k+2+N -> y=1 and y_rise=1 at edge k+3+N. Total N+3 cycles; falling edge is symmetric.
- Glitch rejection:
  - Any return of s_sync to the stable value before counter reaches N-1 aborts the pending change.
  - Pulses on x shorter than N cycles never change y.
  - A bounce restarts counting from 0 on the next qualifying sample.
- Boundary cases:
  - y_rise and y_fall are never high simultaneously.
  - No strobe is generated at reset release.
  - x held at the opposite of PARM_RESET_LEVEL through reset -> change accepted N+3 cycles after the first edge with rstn==1.

Test Plan (N=4, PARM_RESET_LEVEL=0):
- Reset, then x steps 0->1 at edge 10 and holds -> y=0 through edge 16; y=1 and y_rise=1 at edge 17 (N+3=7); y_rise=0 at edge 18.
- x high for 3 cycles then low -> y stays 0, y_rise never asserts; FSM returns to ST_LOW.
- Bouncing rise: x toggles 1,0,1,0,1 (one cycle each), then holds 1 -> y rises exactly once, 7 cycles after the final 0->1 transition; exactly one y_rise pulse.
- y=1 stable, x steps to 0 and holds -> y=0 and y_fall=1 seven cycles later, one cycle wide; y_rise stays 0.
- Drive rstn=0 during ST_RISE_PEND (counter=2) -> next edge y=0, y_rise=0, state ST_LOW; after release with x=0, y remains 0 indefinitely.
- Hold x=1 through reset, release rstn at edge 20 -> y=1 and y_rise=1 at edge 27; no strobe at edge 20.

Source files
------------

// File: rtl/debounce_sync_fsm.sv
// debounce_sync_fsm: two-FF synchronizer plus counting debounce FSM.
// Produces a clean level y and registered one-cycle rise/fall strobes.
module debounce_sync_fsm #(
    parameter int   PARM_DEBOUNCE_CYCLES = 500000,
    parameter logic PARM_RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic x,
    output logic y,
    output logic y_rise,
    output logic y_fall
);

    localparam int CW = $clog2(PARM_DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(PARM_DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_PEND = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_PEND = 2'd3
    } state_t;

    localparam state_t ST_RESET = PARM_RESET_LEVEL ? ST_HIGH : ST_LOW;

    logic          s_meta;
    logic          s_sync;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level;

    // Two-stage synchronizer; only s_sync is allowed into the FSM.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s_meta <= PARM_RESET_LEVEL;
            s_sync <= PARM_RESET_LEVEL;
        end else begin
            s_meta <= x;
            s_sync <= s_meta;
        end
    end

    // State and qualification counter; reset drops any pending change.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_RESET;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a pending change is accepted after N agreeing samples
    // and abandoned the moment the input returns to the stable value.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_LOW: begin
                if (s_sync) begin
                    state_nxt = ST_RISE_PEND;
                    cnt_nxt   = '0;
                end
            end
            ST_RISE_PEND: begin
                if (!s_sync) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_HIGH;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_HIGH: begin
                if (!s_sync) begin
                    state_nxt = ST_FALL_PEND;
                    cnt_nxt   = '0;
                end
            end
            ST_FALL_PEND: begin
                if (s_sync) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_LOW;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Accepted level: pending states still report the old value.
    always_comb begin
        level = (state == ST_HIGH) || (state == ST_FALL_PEND);
    end

    // Registered level and strobes; strobes mark the first cycle of new y.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            y      <= PARM_RESET_LEVEL;
            y_rise <= 1'b0;
            y_fall <= 1'b0;
        end else begin
            y      <= level;
            y_rise <= level & ~y;
            y_fall <= ~level & y;
        end
    end

    // Strobes are mutually exclusive by construction.
    a_strobe_excl : assert property (@(posedge clk) !(y_rise && y_fall));

endmodule

// File: tb/tb_debounce_sync_fsm.sv
// tb_debounce_sync_fsm: directed stimulus with a queued scoreboard.
// Expected {y, y_rise, y_fall} per edge is hand-computed for N=4.
module tb_debounce_sync_fsm;

    logic clk;
    logic rstn;
    logic x;
    logic y;
    logic y_rise;
    logic y_fall;

    logic [2:0] exp_q[$];
    string      tag_q[$];
    logic [2:0] mon_e;
    string      mon_t;
    int         checks;
    int         errors;

    debounce_sync_fsm #(
        .PARM_DEBOUNCE_CYCLES(4),
        .PARM_RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .x(x),
        .y(y),
        .y_rise(y_rise),
        .y_fall(y_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge worth of inputs and queue what that edge must produce.
    task automatic step(input logic xv, input logic rv,
                        input logic [2:0] e, input string t);
        x    = xv;
        rstn = rv;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input int n, input logic xv, input logic rv,
                        input logic [2:0] e, input string t);
        for (int i = 0; i < n; i++) step(xv, rv, e, t);
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            checks++;
            if ({y, y_rise, y_fall} !== mon_e) begin
                errors++;
                $display("FAIL %s @%0t: y/rise/fall=%b%b%b expected %b",
                         mon_t, $time, y, y_rise, y_fall, mon_e);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        x      = 1'b0;
        rstn   = 1'b0;

        // Edges 1-3 reset, 4-9 idle, x high from edge 10 -> rise at 17.
        hold(3, 1'b0, 1'b0, 3'b000, "reset");
        hold(6, 1'b0, 1'b1, 3'b000, "idle_low");
        hold(7, 1'b1, 1'b1, 3'b000, "rise_pend");
        step(1'b1, 1'b1, 3'b110, "rise_edge");
        hold(4, 1'b1, 1'b1, 3'b100, "high_hold");

        // Clean fall: seven cycles later, one-cycle y_fall.
        hold(7, 1'b0, 1'b1, 3'b100, "fall_pend");
        step(1'b0, 1'b1, 3'b001, "fall_edge");
        hold(4, 1'b0, 1'b1, 3'b000, "low_hold");

        // Short pulses (3 and N=4 cycles) are rejected.
        hold(3, 1'b1, 1'b1, 3'b000, "glitch3");
        hold(8, 1'b0, 1'b1, 3'b000, "glitch3_after");
        hold(4, 1'b1, 1'b1, 3'b000, "glitch4");
        hold(8, 1'b0, 1'b1, 3'b000, "glitch4_after");

        // Bounce 1,0,1,0,1 then hold: rise 7 edges after the last 0->1.
        step(1'b1, 1'b1, 3'b000, "bounce");
        step(1'b0, 1'b1, 3'b000, "bounce");
        step(1'b1, 1'b1, 3'b000, "bounce");
        step(1'b0, 1'b1, 3'b000, "bounce");
        hold(7, 1'b1, 1'b1, 3'b000, "bounce_pend");
        step(1'b1, 1'b1, 3'b110, "bounce_rise");
        hold(3, 1'b1, 1'b1, 3'b100, "bounce_high");

        // Return low to set up the mid-pend reset case.
        hold(7, 1'b0, 1'b1, 3'b100, "fall2_pend");
        step(1'b0, 1'b1, 3'b001, "fall2_edge");
        hold(3, 1'b0, 1'b1, 3'b000, "fall2_low");

        // x high for 5 edges reaches RISE_PEND with counter 2, then reset.
        hold(5, 1'b1, 1'b1, 3'b000, "pend_cnt2");
        step(1'b1, 1'b0, 3'b000, "reset_in_pend");
        step(1'b0, 1'b0, 3'b000, "reset_in_pend");
        hold(20, 1'b0, 1'b1, 3'b000, "after_pend_reset");

        // x held high through reset: rise 7 edges after the first rstn=1 edge.
        hold(3, 1'b1, 1'b0, 3'b000, "reset_x_high");
        hold(7, 1'b1, 1'b1, 3'b000, "release_x_high");
        step(1'b1, 1'b1, 3'b110, "release_rise");
        hold(3, 1'b1, 1'b1, 3'b100, "release_high");

        // Reset while high clears y without a fall strobe.
        step(1'b1, 1'b0, 3'b000, "reset_from_high");
        step(1'b0, 1'b0, 3'b000, "reset_from_high");
        hold(3, 1'b0, 1'b1, 3'b000, "final_low");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
